// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions used by the fetch queue and its users.
package fetch_queue_pkg;

  // Instruction presented to decode when no fetched entry is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Queue depth must be a power of two (pointers wrap by overflow) and >= 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_queue_fq_ptr.sv
// Wrapping pointer counter for the fetch queue read and write pointers.
module fq_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = $clog2(DEPTH);

  // Advance on inc. DEPTH is a power of two, so the natural overflow
  // wraps DEPTH-1 back to 0.
  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) ptr <= '0;
    else if (inc)   ptr <= ptr + PTR_W'(1);
  end

endmodule

// File: rtl/fetch_queue.sv
// DEPTH-entry first-word-fall-through buffer between the IF and ID stages.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter int                 ADDR_W = 32,
  parameter int                 DEPTH  = 4,
  parameter logic [DATA_W-1:0]  NOP    = DATA_W'(NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       f_valid,
  input  logic [DATA_W-1:0]          f_instr,
  input  logic [ADDR_W-1:0]          f_pc,
  output logic                       f_ready,
  output logic                       d_valid,
  output logic [DATA_W-1:0]          d_instr,
  output logic [ADDR_W-1:0]          d_pc,
  input  logic                       d_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + ADDR_W;

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and >= 2");
  end

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Handshake flags depend only on occupancy; flush cancels both transfers.
  assign f_ready = (count != CNT_W'(DEPTH));
  assign d_valid = (count != '0);
  assign push    = f_valid && f_ready && !flush;
  assign pop     = d_valid && d_ready && !flush;

  fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  // Write the offered entry into the slot at the write pointer.
  // NOTE: the storage array has no reset; occupancy alone says which slots
  // are live, and leaving it out keeps the array as plain enable flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {f_instr, f_pc};
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag: fetch offered an entry the queue could not take.
  always_ff @(posedge clk) begin
    if (rst)                             err <= 1'b0;
    else if (f_valid && !f_ready && !flush) err <= 1'b1;
  end

  // Head of queue falls through to decode; a bubble when empty.
  // NOTE: every output of this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    d_instr = NOP;
    d_pc    = '0;
    if (d_valid) begin
      d_instr = mem[rd_ptr][ENT_W-1:ADDR_W];
      d_pc    = mem[rd_ptr][ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts
// occupancy/flags, and a monitor checks every popped entry in order.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_valid = 1'b0;
  logic [31:0] f_instr = '0;
  logic [31:0] f_pc = '0;
  logic        f_ready;
  logic        d_valid;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        err;

  fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP(32'h0)) dut (
    .clk     (clk),
    .rst     (rst),
    .f_valid (f_valid),
    .f_instr (f_instr),
    .f_pc    (f_pc),
    .f_ready (f_ready),
    .d_valid (d_valid),
    .d_instr (d_instr),
    .d_pc    (d_pc),
    .d_ready (d_ready),
    .flush   (flush),
    .count   (count),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_entry_t mdl_q[$];   // contents the queue should hold
  bit           mdl_err;
  fetch_entry_t sb_q[$];    // entries decode is expected to receive, in order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all occupancy-derived outputs against the model.
  task automatic check_outputs();
    int n;
    n = mdl_q.size();
    check("count",   64'(count),   64'(n));
    check("d_valid", 64'(d_valid), 64'(n != 0));
    check("f_ready", 64'(f_ready), 64'(n != DEPTH));
    check("err",     64'(err),     64'(mdl_err));
    check("d_instr", 64'(d_instr), (n != 0) ? 64'(mdl_q[0].instr) : 64'(NOP_INSTR));
    check("d_pc",    64'(d_pc),    (n != 0) ? 64'(mdl_q[0].pc) : 64'h0);
  endtask

  // Drive one cycle of stimulus, predict its effect, then check after the edge.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic dr, input logic fl, input logic r);
    fetch_entry_t e;
    bit full, do_pop, do_push;
    f_valid = fv; f_instr = ins; f_pc = pc; d_ready = dr; flush = fl; rst = r;
    e.instr = ins;
    e.pc    = pc;
    if (r) begin
      mdl_q.delete(); sb_q.delete(); mdl_err = 1'b0;
    end else if (fl) begin
      mdl_q.delete(); sb_q.delete();
    end else begin
      full    = (mdl_q.size() == DEPTH);
      do_pop  = dr && (mdl_q.size() != 0);
      do_push = fv && !full;
      if (fv && full) mdl_err = 1'b1;
      if (do_pop) void'(mdl_q.pop_front());
      if (do_push) begin
        mdl_q.push_back(e);
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Monitor: every accepted pop must deliver the oldest outstanding entry.
  always @(negedge clk) begin
    if (!rst && !flush && d_valid && d_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc %0h expected no entry", d_pc);
      end else begin
        check("pop_instr", 64'(d_instr), 64'(sb_q[0].instr));
        check("pop_pc",    64'(d_pc),    64'(sb_q[0].pc));
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] pc;
    mdl_err = 1'b0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Two pushes with decode stalled, then drain
    step(1, 32'h2008_0005, 32'h0, 0, 0, 0);
    step(1, 32'h2009_0003, 32'h4, 0, 0, 0);
    check("tp1_count", 64'(count), 64'd2);
    check("tp1_head",  64'(d_instr), 64'h2008_0005);
    step(0, 0, 0, 1, 0, 0);
    check("tp1_pc4", 64'(d_pc), 64'h4);
    step(0, 0, 0, 1, 0, 0);
    check("tp1_nop", 64'(d_instr), 64'h0);
    step(0, 0, 0, 1, 0, 0);   // empty with d_ready: no pop, no err

    // Overfill: fifth push refused, err set
    for (int i = 0; i < 5; i++) step(1, $urandom, 32'(i * 4), 0, 0, 0);
    check("full_ready", 64'(f_ready), 64'd0);
    check("full_err",   64'(err),     64'd1);
    // Full with push and pop offered: only pop happens
    step(1, 32'hdead_beef, 32'h100, 1, 0, 0);
    check("fullpp_count", 64'(count), 64'd3);
    check("fullpp_head",  64'(d_pc),  64'h4);
    // Flush at count=3 with push and pop offered
    step(1, 32'hbad0_0001, 32'h200, 1, 1, 0);
    check("flush_count", 64'(count), 64'd0);
    step(1, 32'h1234_5678, 32'h40, 0, 0, 0);
    check("post_flush_pc", 64'(d_pc), 64'h40);
    step(0, 0, 0, 1, 0, 0);

    // Sustained push+pop across pointer wrap
    step(0, 0, 0, 0, 0, 1);
    step(1, $urandom, 32'h0, 0, 0, 0);
    for (int i = 1; i < 10; i++) step(1, $urandom, 32'(i * 4), 1, 0, 0);
    check("stream_count", 64'(count), 64'd1);
    check("stream_err",   64'(err),   64'd0);
    step(0, 0, 0, 1, 0, 0);

    // Reset at count=3 with err set
    for (int i = 0; i < 5; i++) step(1, $urandom, 32'(i * 4), 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err",   64'(err),   64'd0);

    // Randomised traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic fv, dr, fl, r;
      fv = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 99) < 4);
      r  = ($urandom_range(0, 199) < 1);
      step(fv, $urandom, pc, dr, fl, r);
      pc = pc + 32'h4;
    end
    step(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue between the IF and ID stages of the pipelined CPU, generalising the single-entry IF/ID register into a DEPTH-entry first-word-fall-through buffer. Fetch pushes {instruction, PC} pairs; decode pops them under a valid/ready handshake. The hazard unit's stall maps onto the handshake (decode not ready). Branch resolution in ID drives a flush, which empties the queue in one cycle. Empty queue presents a NOP bubble to decode.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, PC width
- DEPTH, 4, number of entries; power of two, >= 2
- NOP, 0, instruction value presented on d_instr when queue is empty
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- f_valid  in  1  fetch offers an entry this cycle
- f_instr  in  DATA_W  fetched instruction
- f_pc  in  ADDR_W  PC of fetched instruction
- f_ready  out  1  queue can accept (not full)
- d_valid  out  1  head entry valid (queue not empty)
- d_instr  out  DATA_W  head instruction; NOP when empty
- d_pc  out  ADDR_W  head PC; 0 when empty
- d_ready  in  1  decode consumes head this cycle (0 = ID stall)
- flush  in  1  discard all entries (taken branch / jump)
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- err  out  1  sticky: push attempted while f_ready=0

## Operation
- Storage: DEPTH-entry array of {instr, pc}; rd_ptr, wr_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; occupancy register count.
- push = f_valid & f_ready; pop = d_valid & d_ready.
- f_ready = (count != DEPTH); d_valid = (count != 0); both combinational from count only (no dependence on d_ready or f_valid).
- d_instr/d_pc = array[rd_ptr] when d_valid, else NOP/0.
- Per cycle, priority order: rst, flush, push/pop.
- flush: count, rd_ptr, wr_ptr <= 0; concurrent push and pop discarded; err unchanged.
- push only: write array[wr_ptr], wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1. Both: both pointers advance, count unchanged.
- Full with f_valid=1 and d_ready=1: pop happens, push refused (f_ready=0); next count = DEPTH-1; err set.
- Empty with d_ready=1: no pop, no error (decode ready is a level).
- err set when f_valid & !f_ready & !flush; cleared only by rst.

## Timing
- Reset values: count=0, d_valid=0, d_instr=NOP, d_pc=0, f_ready=1, err=0; pointers 0; array contents don't-care.
- Latency: entry pushed at edge t is on d_* at cycle t+1 (one cycle, no combinational bypass).
- Pop at edge t exposes next entry in cycle t+1.
- Flush at edge t: d_valid=0, f_ready=1 in cycle t+1; push in cycle t+1 visible in t+2.
- rst during any occupancy behaves as flush plus err clear.
- Throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH-1.

## Structure
- Shared CPU package: NOP_INSTR constant (32'h0000_0000), fetch entry struct {instr, pc}, DEPTH legality check.
- One sub-module natural: fq_ptr, a wrapping pointer counter (parameter DEPTH; clk, rst, clr, inc, ptr), instantiated for rd_ptr and wr_ptr.
- Storage is a flop array; no memory macro.

## Test plan
- Reset then push 0x20080005 @PC 0x0, 0x20090003 @PC 0x4 with d_ready=0 -> count=2; d_instr=0x20080005, d_pc=0x0; d_ready=1 for 2 cycles -> d_pc 0x4 then empty, d_instr=NOP.
- DEPTH=4, push 5 entries with d_ready=0 -> f_ready=0 at count=4; 5th push refused; err=1; contents PC 0x0..0xC pop in order.
- Full queue, f_valid=1, d_ready=1 one cycle -> count=3, head PC 0x4, err=1, wr_ptr unchanged.
- count=3, assert flush with f_valid=1 and d_ready=1 -> next cycle count=0, d_valid=0, d_instr=NOP; following push of PC 0x40 appears one cycle later.
- Continuous push+pop over 10 cycles with ptr wrap (PCs 0x0..0x24) -> count stays 1, output PC sequence intact, no err.
- rst asserted at count=3, err=1 -> next cycle all outputs at reset values.
